// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package muldiv_defs;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply (mode=0) or restoring divide (mode=1).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] opnd,
    input  logic             mode,
    output logic [2*WIDTH:0] acc_next,
    output logic             qbit
);

    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Multiply: acc = {carry, partial product, multiplier}; divide: acc = {remainder, quotient/dividend}
    always_comb begin
        upper    = acc[2*WIDTH:WIDTH];
        sum      = acc[0] ? (upper + {1'b0, opnd}) : upper;
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, opnd};
        qbit     = 1'b0;
        acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        if (mode) begin
            qbit     = ~diff[WIDTH+1];
            acc_next = {(qbit ? diff[WIDTH:0] : shifted), acc[WIDTH-2:0], qbit};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Latency: start edge + WIDTH RUN cycles + 1 FIX cycle; done pulses in the first IDLE cycle.
// Backpressure: busy high while in flight; start (any op) is ignored until back in IDLE.
import muldiv_defs::*;

module muldiv_unit #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_lo;    // negate product (mult) or quotient (div)
    logic               neg_hi;    // negate remainder (div only)

    logic               sgn;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH:0]   step_acc;
    logic               step_q;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .opnd     (opnd),
        .mode     (is_div),
        .acc_next (step_acc),
        .qbit     (step_q)
    );

    // Operand conditioning at launch: signed ops iterate on magnitudes
    always_comb begin
        sgn   = ~op[0];
        mag_a = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    end

    // Sign fix-up of the raw iteration result, evaluated while in FIX
    always_comb begin
        prod   = neg_lo ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM, iteration datapath and architectural HI/LO
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                acc    <= {{(WIDTH+1){1'b0}}, mag_a};
                                opnd   <= mag_b;
                                is_div <= op[1];
                                // a zero divisor keeps quotient all-ones; remainder then equals a
                                neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && (!op[1] || (b != '0));
                                neg_hi <= sgn && a[WIDTH-1];
                                cnt    <= CNT_W'(WIDTH - 1);
                                state  <= S_RUN;
                                busy   <= 1'b1;
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc <= step_acc;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
// Latency: checks start-to-done edge count and busy duration per op.
// Backpressure: exercises ignored starts while busy and back-to-back launches.
import muldiv_defs::*;

module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics straight from arithmetic
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sp;
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        p  = '0;
        eh = '0;
        el = '0;
        case (o)
            MD_MULT: begin
                sp = longint'(sx) * longint'(sy);
                p  = sp;
                eh = p[63:32];
                el = p[31:0];
            end
            MD_MULTU: begin
                p  = {32'b0, x} * {32'b0, y};
                eh = p[63:32];
                el = p[31:0];
            end
            MD_DIV: begin
                if (y == 0) begin
                    el = 32'hFFFF_FFFF; eh = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'h0;
                end else begin
                    el = sx / sy; eh = sx % sy;
                end
            end
            default: begin
                if (y == 0) begin
                    el = 32'hFFFF_FFFF; eh = x;
                end else begin
                    el = x / y; eh = x % y;
                end
            end
        endcase
    endtask

    // Launch a MULT/DIV (entered at #1 after an edge or earlier), wait for done, check everything.
    // If inj is set, an MTLO start is driven mid-flight and must be ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inj);
        logic [31:0] eh, el;
        int n, nb;
        bit stable;
        model(o, x, y, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; nb = 0; stable = 1'b1;
        while (n < 100) begin
            if (busy) nb++;
            if (done) break;
            if (hi !== mhi || lo !== mlo) stable = 1'b0;
            if (inj && n == 5) begin
                start = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_edges"}, 64'(n), 64'd34);
        check({tag, "_busycyc"}, 64'(nb), 64'd33);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_stable"}, 64'(stable), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        mhi = eh;
        mlo = el;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases, each launched back-to-back in the previous done cycle
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'h3, 1'b0);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_b2b", MD_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_z", MD_DIVU, 32'd100, 32'd0, 1'b0);
        run_op("div_z", MD_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);

        // MTHI in IDLE: single cycle, no busy, no done
        @(negedge clk);
        start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        mhi = 32'h1234_5678;
        check("mthi_hi", 64'(hi), 64'(mhi));
        check("mthi_lo", 64'(lo), 64'(mlo));
        check("mthi_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("mthi_nodone", 64'(done), 64'd0);

        // Reserved op ignored
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 32'hAAAA_5555; b = 32'h5;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("rsvd_quiet", 64'(dones), 64'd0);
        check("rsvd_hi", 64'(hi), 64'(mhi));
        check("rsvd_lo", 64'(lo), 64'(mlo));

        // MTLO during in-flight MULT is dropped
        run_op("mult_mtlo", MD_MULT, 32'd7, 32'hFFFF_FFF7, 1'b1);

        // Reset mid-operation aborts without a result
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        mhi = '0; mlo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk) reset = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_nodone", 64'(dones), 64'd0);
        run_op("mult_after_rst", MD_MULT, 32'd3, 32'd5, 1'b0);

        // Randomized MULT/DIV mix
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 3));
            run_op("rand", ro, pick(), pick(), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
